// File: rtl/oam_dma_ctrl.sv
// Sprite DMA sequencer: a CPU write to DMA_REG stalls the CPU, copies one
// page of CPU memory into OAM as READ/WRITE pairs, then releases the CPU.
// The stall is 513 cycles, or 514 when an ALIGN cycle is needed for parity.
//
// Strobe semantics: bus_ren and oam_wen are single-cycle, always-accepted
// strobes (no ready back-pressure). Memory answers a bus_ren one cycle later
// on bus_rdata, and that value is forwarded to oam_wdata in the WRITE cycle.
module oam_dma_ctrl #(
   parameter logic [15:0] DMA_REG  = 16'h4014,
   parameter int          XFER_LEN = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_wen,
   output logic        cpu_stall,
   output logic [15:0] bus_addr,
   output logic        bus_ren,
   input  logic [7:0]  bus_rdata,
   output logic [7:0]  oam_addr,
   output logic [7:0]  oam_wdata,
   output logic        oam_wen,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HALT  = 3'd1,
      ALIGN = 3'd2,
      READ  = 3'd3,
      WRITE = 3'd4
   } state_t;

   localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

   state_t     state, state_n;
   logic [7:0] page, page_n;
   logic [7:0] idx, idx_n;
   logic       par;
   logic       trig;

   assign trig = cpu_wen && (cpu_addr == DMA_REG);

   // Next-state logic; the page and index only change on an accepted trigger
   // or when stepping to the next byte.
   always_comb begin
      state_n = state;
      page_n  = page;
      idx_n   = idx;
      case (state)
         IDLE: begin
            if (trig) begin
               state_n = HALT;
               page_n  = cpu_wdata;
               idx_n   = 8'h00;
            end
         end
         HALT:  state_n = par ? ALIGN : READ;
         ALIGN: state_n = READ;
         READ:  state_n = WRITE;
         WRITE: begin
            if (idx == LAST_IDX) begin
               state_n = IDLE;
            end else begin
               idx_n   = idx + 8'h01;
               state_n = READ;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State registers plus outputs registered from the next-state decode, so
   // every output except oam_wdata comes straight from a flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         page      <= 8'h00;
         idx       <= 8'h00;
         par       <= 1'b0;
         cpu_stall <= 1'b0;
         bus_ren   <= 1'b0;
         bus_addr  <= 16'h0000;
         oam_wen   <= 1'b0;
         oam_addr  <= 8'h00;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         page      <= page_n;
         idx       <= idx_n;
         par       <= ~par;
         cpu_stall <= (state_n != IDLE);
         bus_ren   <= (state_n == READ);
         bus_addr  <= (state_n != IDLE) ? {page_n, idx_n} : 16'h0000;
         oam_wen   <= (state_n == WRITE);
         oam_addr  <= (state_n != IDLE) ? idx_n : 8'h00;
         done      <= (state == WRITE) && (state_n == IDLE);
      end
   end

   // Read data arrives one cycle after bus_ren, i.e. during WRITE.
   assign oam_wdata = oam_wen ? bus_rdata : 8'h00;
   assign busy      = cpu_stall;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: memory and OAM models around the DUT,
// stall-length / first-read / content checks per transfer.
module tb_oam_dma_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_wen;
   logic        cpu_stall;
   logic [15:0] bus_addr;
   logic        bus_ren;
   logic [7:0]  bus_rdata;
   logic [7:0]  oam_addr;
   logic [7:0]  oam_wdata;
   logic        oam_wen;
   logic        busy;
   logic        done;

   int          n_vec  = 0;
   int          n_miss = 0;
   int          cyc;
   int          wr_cnt = 0;
   logic [7:0]  oam [256];
   logic [31:0] exp_q[$];

   // clock / reset block
   always #5 clk = ~clk;

   oam_dma_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_wen   (cpu_wen),
      .cpu_stall (cpu_stall),
      .bus_addr  (bus_addr),
      .bus_ren   (bus_ren),
      .bus_rdata (bus_rdata),
      .oam_addr  (oam_addr),
      .oam_wdata (oam_wdata),
      .oam_wen   (oam_wen),
      .busy      (busy),
      .done      (done)
   );

   // cycles since reset release; equals the DUT parity count
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   function automatic logic [7:0] mem_val(input logic [15:0] a);
      return (a[7:0] ^ 8'hA5) + a[15:8];
   endfunction

   // memory with one cycle read latency
   always @(posedge clk) begin
      bus_rdata <= bus_ren ? mem_val(bus_addr) : 8'h00;
   end

   // OAM model
   always @(posedge clk) begin
      if (oam_wen) begin
         oam[oam_addr] <= oam_wdata;
         wr_cnt <= wr_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic outputs_idle(input string tag);
      check(tag, {15'd0, cpu_stall, bus_addr, bus_ren},
                 32'h0);
      check({tag, "_oam"}, {13'd0, oam_addr, oam_wdata, oam_wen, busy, done}, 32'h0);
   endtask

   // driver: trigger so that the HALT cycle sees the requested parity
   task automatic trigger(input logic [7:0] pg, input int want_par);
      @(negedge clk);
      while (((cyc + 1) % 2) != want_par) @(negedge clk);
      cpu_addr  = 16'h4014;
      cpu_wdata = pg;
      cpu_wen   = 1'b1;
      @(posedge clk);
      #1;
      cpu_wen   = 1'b0;
   endtask

   // monitor one transfer starting at cycle T+1; optional mid-transfer
   // rogue trigger and optional chained trigger in the done cycle
   task automatic watch(input string tag, input logic [7:0] pg, input int par_h,
                        input bit inject, input bit chain, input logic [7:0] pg2,
                        output int par_out);
      int  stall_cnt = 0;
      int  first_ren = -1;
      int  rd_idx = 0;
      int  bad_addr = 0;
      int  bad_oam = 0;
      int  wr0 = wr_cnt;
      bit  seen = 0;
      par_out = 0;
      check({tag, "_stall_t1"}, 32'(cpu_stall), 32'h1);
      for (int k = 1; k < 700; k++) begin
         if (done) begin
            seen = 1;
            break;
         end
         if (cpu_stall) stall_cnt++;
         if (bus_ren) begin
            if (first_ren < 0) first_ren = k;
            if (bus_addr != {pg, 8'(rd_idx)}) bad_addr++;
            rd_idx++;
         end
         if (inject && k == 100) begin
            cpu_addr = 16'h4014; cpu_wdata = 8'h05; cpu_wen = 1'b1;
         end
         if (inject && k == 101) cpu_wen = 1'b0;
         @(posedge clk);
         #1;
      end
      check({tag, "_done_seen"}, 32'(seen), 32'h1);
      check({tag, "_stall_len"}, 32'(stall_cnt), 32'(513 + par_h));
      check({tag, "_first_ren"}, 32'(first_ren), 32'(2 + par_h));
      check({tag, "_reads"}, 32'(rd_idx), 32'd256);
      check({tag, "_bad_addr"}, 32'(bad_addr), 32'd0);
      check({tag, "_writes"}, 32'(wr_cnt - wr0), 32'd256);
      check({tag, "_done_unstall"}, 32'(cpu_stall), 32'h0);
      for (int i = 0; i < 256; i++) begin
         if (oam[i] !== mem_val({pg, 8'(i)})) bad_oam++;
         oam[i] = 8'h00;
      end
      check({tag, "_oam_data"}, 32'(bad_oam), 32'd0);
      if (chain) begin
         cpu_addr = 16'h4014; cpu_wdata = pg2; cpu_wen = 1'b1;
         @(posedge clk);
         #1;
         cpu_wen = 1'b0;
         par_out = cyc % 2;
      end else begin
         @(posedge clk);
         #1;
         check({tag, "_done_once"}, 32'(done), 32'h0);
         check({tag, "_idle_after"}, 32'(busy), 32'h0);
      end
   endtask

   initial begin
      int p;
      int wr_hold;
      int bound;
      rst = 1'b1; cpu_addr = 16'h0; cpu_wdata = 8'h0; cpu_wen = 1'b0;
      for (int i = 0; i < 256; i++) oam[i] = 8'h00;
      exp_q.push_back(32'h0);
      repeat (3) @(posedge clk);
      #1;
      outputs_idle("reset");
      @(negedge clk);
      rst = 1'b0;

      // 1: parity 0 in HALT -> 513 cycles
      trigger(8'h02, 0);
      watch("p0", 8'h02, 0, 0, 0, 8'h00, p);

      // 2: parity 1 in HALT -> ALIGN, 514 cycles, rogue write ignored
      trigger(8'h02, 1);
      watch("p1_inject", 8'h02, 1, 1, 0, 8'h00, p);

      // 3: non-trigger bus activity
      @(negedge clk); cpu_addr = 16'h4013; cpu_wdata = 8'h07; cpu_wen = 1'b1;
      @(negedge clk); check("addr_4013", 32'(busy), 32'h0);
      cpu_addr = 16'h4015;
      @(negedge clk); check("addr_4015", 32'(busy), 32'h0);
      cpu_addr = 16'h4014; cpu_wen = 1'b0;
      @(negedge clk); check("read_4014", 32'(busy), 32'h0);
      @(negedge clk); check("read_4014_stall", 32'(cpu_stall), 32'h0);

      // 4: reset mid-transfer
      trigger(8'h02, 0);
      bound = 0;
      while (!(oam_wen && oam_addr == 8'h40) && bound < 600) begin
         @(posedge clk); #1; bound++;
      end
      check("reach_oam_40", 32'(bound < 600), 32'h1);
      rst = 1'b1;
      #1;
      outputs_idle("async_rst");
      wr_hold = wr_cnt;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("no_wr_after_rst", 32'(wr_cnt - wr_hold), 32'h0);
      check("idle_after_rst", 32'(busy), 32'h0);
      for (int i = 0; i < 256; i++) oam[i] = 8'h00;
      trigger(8'h03, 1);
      watch("post_rst", 8'h03, 1, 0, 0, 8'h00, p);

      // 5: trigger in the done cycle, then a second page
      trigger(8'h02, 0);
      watch("chain_a", 8'h02, 0, 0, 1, 8'h07, p);
      check("chain_halt", 32'(busy), 32'h1);
      watch("chain_b", 8'h07, p, 0, 0, 8'h00, p);

      void'(exp_q.pop_front());
      check("exp_q_drained", 32'(exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/oam_dma_ctrl.md
# oam_dma_ctrl

Sprite DMA sequencer for the NES core. It snoops CPU writes to the DMA register ($4014), stalls the 6502 and takes over the CPU memory bus. It copies one 256-byte CPU page into PPU object attribute memory (OAM) as alternating read/write cycles. It then releases the CPU, with NES-accurate stall length of 513 or 514 cycles depending on start-cycle parity.

## Interface
Parameters:
- DMA_REG, 16'h4014, CPU address whose write triggers a transfer
- XFER_LEN, 256, bytes per transfer; must be a power of two, max 256

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- cpu_addr  in  16  CPU bus address
- cpu_wdata  in  8  CPU write data; on trigger, the source page number
- cpu_wen  in  1  CPU write strobe
- cpu_stall  out  1  holds CPU (no pc advance, no bus drive) while high
- bus_addr  out  16  DMA read address to CPU memory
- bus_ren  out  1  DMA read strobe
- bus_rdata  in  8  memory read data, valid the cycle after bus_ren
- oam_addr  out  8  OAM write index
- oam_wdata  out  8  OAM write data
- oam_wen  out  1  OAM write strobe
- busy  out  1  transfer in progress (equals cpu_stall)
- done  out  1  one-cycle pulse after last OAM write

## Operation
- Trigger: rising clk with cpu_wen=1, cpu_addr==DMA_REG, state IDLE. It latches page <= cpu_wdata and sets idx <= 0.
- A trigger while not IDLE is ignored. Page and idx are unchanged.
- Parity bit par: reset 0, toggles every clk cycle unconditionally.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE -> HALT on trigger.
- HALT (1 cycle) -> ALIGN if par==1, else READ.
- ALIGN (1 cycle) -> READ.
- READ: bus_ren=1, bus_addr={page, idx}. -> WRITE.
- WRITE: oam_wen=1, oam_addr=idx, oam_wdata=bus_rdata.
  - If idx==XFER_LEN-1: -> IDLE.
  - Else: idx <= idx+1, -> READ.
- Outputs are registered decodes of the state, except oam_wdata. oam_wdata = bus_rdata while oam_wen=1, else 0.
- bus_addr holds {page, idx} in every non-IDLE state and is 0 in IDLE.
- idx is 8 bits. It never wraps within a transfer, and page never increments (no page crossing).
- cpu_stall=busy=1 in HALT, ALIGN, READ and WRITE.
- done=1 for exactly the first IDLE cycle after the final WRITE.

## Timing
- Reset values: cpu_stall=0, busy=0, bus_ren=0, bus_addr=0, oam_wen=0, oam_addr=0, oam_wdata=0, done=0, state IDLE, par=0, idx=0, page=0.
- Trigger sampled at edge T. cpu_stall is high from cycle T+1.
- Stall length for XFER_LEN=256:
  - 513 cycles when par==0 in HALT: 1 HALT + 512 READ/WRITE.
  - 514 cycles when par==1: adds ALIGN.
- First bus_ren: cycle T+2 (no ALIGN) or T+3 (ALIGN).
- Read/write pairs are back-to-back, so one byte moves every 2 cycles.
- Last oam_wen cycle is followed directly by done=1 and cpu_stall=0 in the same cycle.
- A new trigger is accepted in the same cycle that done=1.
- Memory read latency is fixed at 1. bus_rdata sampled during WRITE belongs to the preceding READ address.
- rst asserted mid-transfer immediately forces all outputs to reset values and state to IDLE, with no further OAM writes. done is not pulsed.
- cpu_wen with a non-DMA_REG address has no effect in any state.

## Test plan
- Reset then trigger (write 8'h02 to 16'h4014) at a cycle with par==0 -> cpu_stall high 513 cycles. bus_addr sweeps 16'h0200..16'h02FF. OAM[i] == mem[16'h0200+i] for all i. done pulses once.
- Same trigger, delayed one cycle so par==1 in HALT -> one ALIGN cycle, cpu_stall high 514 cycles, first bus_ren 3 cycles after trigger edge.
- Second write to 16'h4014 (data 8'h05) issued mid-transfer -> ignored. All 256 bytes still come from page 8'h02.
- rst pulsed after oam_addr reaches 8'h40 -> all outputs 0 asynchronously. No oam_wen afterwards. A fresh trigger then completes a normal 513/514-cycle transfer.
- Write to 16'h4013 and 16'h4015 with cpu_wen=1, and a read of 16'h4014 with cpu_wen=0 -> no stall, busy stays 0.
- Trigger issued in the done cycle -> accepted; HALT follows next cycle with no idle gap in busy beyond the done cycle.
